// File: rtl/timer_bank_pkg.sv
// Shared register-map constants and helpers for the timer bank.
// Offsets are relative to a channel base; TCON bit positions are fixed across widths.
package timer_bank_pkg;

    localparam logic [3:0] OFF_TH   = 4'h0;
    localparam logic [3:0] OFF_TL   = 4'h4;
    localparam logic [3:0] OFF_TCON = 4'h8;
    localparam logic [3:0] OFF_OVF  = 4'hC;

    localparam int TCON_EN        = 0;
    localparam int TCON_IE        = 1;
    localparam int TCON_PEND      = 2;
    localparam int TCON_ONESHOT   = 3;
    localparam int TCON_PRESC_LSB = 8;

    localparam int OVF_W = 8;

    function automatic logic [OVF_W-1:0] ovf_sat_inc(input logic [OVF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/timer_bank_if.sv
// CPU peripheral bus as seen by the timer bank: strobes, address, data.
// rdata is combinational from the slave in the same cycle as rd.
interface timer_bank_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/timer_bank_channel.sv
// One reload timer: TH/TL/TCON/OVF plus prescaler, updated on the rising edge.
// Register writes win over counting on the same edge; hardware PEND set wins over W1C.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wdata_i,
    input  logic        th_wr_i,
    input  logic        tl_wr_i,
    input  logic        tcon_wr_i,
    input  logic        ovf_rd_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic [31:0] tcon_o,
    output logic [31:0] ovf_o,
    output logic        irq_o
);

    logic [CNT_W-1:0]   th_q, th_d, tl_q, tl_d;
    logic [PRESC_W-1:0] presc_q, presc_d, pc_q, pc_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;
    logic               en_q, en_d, ie_q, ie_d, pend_q, pend_d, os_q, os_d;
    logic               tick, ovf_evt;
    logic               unused_wdata;

    assign unused_wdata = ^wdata_i;

    assign tick    = en_q && (pc_q == presc_q);
    // A TL write on the same edge suppresses both the increment and the overflow.
    assign ovf_evt = tick && (&tl_q) && !tl_wr_i;

    always_comb begin
        th_d    = th_q;
        tl_d    = tl_q;
        presc_d = presc_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        en_d    = en_q;
        ie_d    = ie_q;
        pend_d  = pend_q;
        os_d    = os_q;

        if (th_wr_i) th_d = wdata_i[CNT_W-1:0];

        if (tcon_wr_i || tick) pc_d = '0;
        else if (en_q)         pc_d = pc_q + 1'b1;

        // Overflow reloads from the TH value held before this edge.
        if (tl_wr_i)      tl_d = wdata_i[CNT_W-1:0];
        else if (ovf_evt) tl_d = th_q;
        else if (tick)    tl_d = tl_q + 1'b1;

        if (tcon_wr_i) begin
            en_d    = wdata_i[TCON_EN];
            ie_d    = wdata_i[TCON_IE];
            os_d    = wdata_i[TCON_ONESHOT];
            presc_d = wdata_i[TCON_PRESC_LSB +: PRESC_W];
        end else if (ovf_evt && os_q) begin
            en_d = 1'b0;
        end

        if (ovf_evt && ie_q)                         pend_d = 1'b1;
        else if (tcon_wr_i && wdata_i[TCON_PEND])    pend_d = 1'b0;

        if (ovf_evt) ovf_d = ovf_rd_i ? OVF_W'(1) : ovf_sat_inc(ovf_q);
        else if (ovf_rd_i) ovf_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q    <= '0;
            tl_q    <= '0;
            presc_q <= '0;
            pc_q    <= '0;
            ovf_q   <= '0;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            pend_q  <= 1'b0;
            os_q    <= 1'b0;
        end else begin
            th_q    <= th_d;
            tl_q    <= tl_d;
            presc_q <= presc_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            pend_q  <= pend_d;
            os_q    <= os_d;
        end
    end

    always_comb begin
        tcon_o                                 = '0;
        tcon_o[TCON_EN]                        = en_q;
        tcon_o[TCON_IE]                        = ie_q;
        tcon_o[TCON_PEND]                      = pend_q;
        tcon_o[TCON_ONESHOT]                   = os_q;
        tcon_o[TCON_PRESC_LSB +: PRESC_W]      = presc_q;
    end

    assign th_o  = 32'(th_q);
    assign tl_o  = 32'(tl_q);
    assign ovf_o = 32'(ovf_q);
    assign irq_o = pend_q & ie_q;

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of NUM_CH reload timers with a masked CPU interrupt output.
// Reads are combinational; writes and clear-on-read land on the next rising edge.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter int          PRESC_W   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
    input  logic              clk,
    input  logic              reset,
    timer_bank_if.slave       bus,
    input  logic              PC31,
    output logic              irqout,
    output logic [NUM_CH-1:0] irq_vec
);

    logic [31:0]       rel;
    logic              hit;
    logic [2:0]        ch_sel;
    logic [3:0]        off;
    logic [NUM_CH-1:0] irq;

    logic [31:0] th_rv   [NUM_CH];
    logic [31:0] tl_rv   [NUM_CH];
    logic [31:0] tcon_rv [NUM_CH];
    logic [31:0] ovf_rv  [NUM_CH];

    // With a 16-byte aligned base the low nibble of rel equals addr[3:0].
    assign rel    = bus.addr - BASE_ADDR;
    assign hit    = (bus.addr >= BASE_ADDR) && (rel[31:4] < 28'(NUM_CH));
    assign ch_sel = rel[6:4];
    assign off    = rel[3:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = hit && (ch_sel == 3'(i));

        timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wdata_i   (bus.wdata),
            .th_wr_i   (bus.wr && sel && (off == OFF_TH)),
            .tl_wr_i   (bus.wr && sel && (off == OFF_TL)),
            .tcon_wr_i (bus.wr && sel && (off == OFF_TCON)),
            .ovf_rd_i  (bus.rd && sel && (off == OFF_OVF)),
            .th_o      (th_rv[i]),
            .tl_o      (tl_rv[i]),
            .tcon_o    (tcon_rv[i]),
            .ovf_o     (ovf_rv[i]),
            .irq_o     (irq[i])
        );
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && hit) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_sel == 3'(i)) begin
                    case (off)
                        OFF_TH:   bus.rdata = th_rv[i];
                        OFF_TL:   bus.rdata = tl_rv[i];
                        OFF_TCON: bus.rdata = tcon_rv[i];
                        OFF_OVF:  bus.rdata = ovf_rv[i];
                        default:  bus.rdata = '0;
                    endcase
                end
            end
        end
    end

    assign irq_vec = irq;
    assign irqout  = ~PC31 & (|irq);

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: register map, counting, prescaler, one-shot,
// overflow counter saturation, same-edge priorities and asynchronous reset.
module tb_timer_bank;
    import timer_bank_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0100;

    logic       clk = 1'b0;
    logic       reset;
    logic       PC31;
    logic       irqout;
    logic [3:0] irq_vec;
    int         n_pass = 0;
    int         n_fail = 0;
    int         n_tot  = 0;
    logic [31:0] v;

    timer_bank_if bus ();

    timer_bank #(
        .NUM_CH    (4),
        .CNT_W     (32),
        .PRESC_W   (8),
        .BASE_ADDR (BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .PC31    (PC31),
        .irqout  (irqout),
        .irq_vec (irq_vec)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] A(input int ch, input logic [3:0] o);
        return BASE + 32'(16 * ch) + 32'(o);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Non-destructive read inside the low clock phase: no edge sees rd.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.rd   = 1'b1;
        #1;
        d        = bus.rdata;
        bus.rd   = 1'b0;
        bus.addr = '0;
    endtask

    // Read held across one rising edge, so OVF clear-on-read takes effect.
    task automatic rd_clr(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a;
        bus.rd   = 1'b1;
        #1;
        d = bus.rdata;
        @(negedge clk);
        bus.rd   = 1'b0;
        bus.addr = '0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr    = 1'b1;
        @(negedge clk);
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        PC31 = 1'b0;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;

        // Reset state of every register
        for (int ch = 0; ch < 4; ch++) begin
            for (int o = 0; o < 16; o += 4) begin
                peek(A(ch, 4'(o)), v);
                check($sformatf("reset ch%0d off%0h", ch, o), v, 32'h0);
            end
            idle(1);
        end
        check("reset irqout", 32'(irqout), 32'h0);
        check("reset irq_vec", 32'(irq_vec), 32'h0);

        // Ch0: overflow with IE, PEND two edges after enabling
        wr_reg(A(0, OFF_TH), 32'hFFFF_FFFC);
        wr_reg(A(0, OFF_TL), 32'hFFFF_FFFE);
        wr_reg(A(0, OFF_TCON), 32'h3);
        idle(2);
        peek(A(0, OFF_TCON), v); check("ch0 pend set", v, 32'h7);
        peek(A(0, OFF_TL), v);   check("ch0 reload", v, 32'hFFFF_FFFC);
        check("ch0 irqout unmasked", 32'(irqout), 32'h1);
        check("ch0 irq_vec", 32'(irq_vec), 32'h1);
        PC31 = 1'b1; #1;
        check("ch0 irqout masked", 32'(irqout), 32'h0);
        check("ch0 irq_vec masked", 32'(irq_vec), 32'h1);
        PC31 = 1'b0;
        wr_reg(A(0, OFF_TCON), 32'h7);
        peek(A(0, OFF_TCON), v); check("ch0 w1c", v, 32'h3);
        check("ch0 irqout cleared", 32'(irqout), 32'h0);
        wr_reg(A(0, OFF_TCON), 32'h0);
        peek(A(0, OFF_TL), v);   check("ch0 stopped tl", v, 32'hFFFF_FFFE);

        // Unmapped / rd=0 reads
        bus.addr = A(0, OFF_TL); #1;
        check("rd0 returns 0", bus.rdata, 32'h0);
        bus.addr = '0;
        peek(A(4, OFF_TL), v);       check("unmapped above", v, 32'h0);
        peek(BASE - 32'd4, v);       check("unmapped below", v, 32'h0);
        peek(A(0, 4'h2), v);         check("unaligned offset", v, 32'h0);

        // Ch1: prescaler 3, one increment every 4 ticks
        wr_reg(A(1, OFF_TL), 32'h0);
        wr_reg(A(1, OFF_TCON), 32'h301);
        idle(7);
        peek(A(1, OFF_TL), v); check("ch1 tl after 7", v, 32'h1);
        idle(1);
        peek(A(1, OFF_TL), v); check("ch1 tl after 8", v, 32'h2);
        idle(2);
        wr_reg(A(1, OFF_TCON), 32'h301);
        idle(3);
        peek(A(1, OFF_TL), v); check("ch1 pc reset hold", v, 32'h2);
        idle(1);
        peek(A(1, OFF_TL), v); check("ch1 pc reset inc", v, 32'h3);
        peek(A(1, OFF_TCON), v); check("ch1 tcon readback", v, 32'h301);
        wr_reg(A(1, OFF_TCON), 32'h0);

        // Ch2: one-shot overflow without IE
        wr_reg(A(2, OFF_TH), 32'h10);
        wr_reg(A(2, OFF_TL), 32'hFFFF_FFFF);
        wr_reg(A(2, OFF_TCON), 32'h9);
        idle(1);
        peek(A(2, OFF_TCON), v); check("ch2 oneshot en off", v, 32'h8);
        peek(A(2, OFF_TL), v);   check("ch2 reload", v, 32'h10);
        check("ch2 no irq", 32'(irq_vec), 32'h0);
        idle(2);
        peek(A(2, OFF_TL), v);   check("ch2 stays stopped", v, 32'h10);
        rd_clr(A(2, OFF_OVF), v); check("ch2 ovf first read", v, 32'h1);
        peek(A(2, OFF_OVF), v);   check("ch2 ovf cleared", v, 32'h0);
        wr_reg(A(2, OFF_OVF), 32'h55);
        peek(A(2, OFF_OVF), v);   check("ch2 ovf write ignored", v, 32'h0);

        // Ch2: 300 free-running overflows saturate OVF
        wr_reg(A(2, OFF_TH), 32'hFFFF_FFFF);
        wr_reg(A(2, OFF_TL), 32'hFFFF_FFFF);
        wr_reg(A(2, OFF_TCON), 32'h1);
        idle(300);
        peek(A(2, OFF_OVF), v);   check("ch2 ovf saturated", v, 32'd255);
        rd_clr(A(2, OFF_OVF), v); check("ch2 read on overflow edge", v, 32'd255);
        peek(A(2, OFF_OVF), v);   check("ch2 ovf restarts at 1", v, 32'd1);
        wr_reg(A(2, OFF_TCON), 32'h0);

        // Ch3: TL write and W1C PEND both racing an overflow
        wr_reg(A(3, OFF_TH), 32'h5);
        wr_reg(A(3, OFF_TL), 32'hFFFF_FFFE);
        wr_reg(A(3, OFF_TCON), 32'h3);
        idle(1);
        peek(A(3, OFF_TL), v);   check("ch3 at all-ones", v, 32'hFFFF_FFFF);
        wr_reg(A(3, OFF_TL), 32'h1234);
        peek(A(3, OFF_TL), v);   check("ch3 tl write wins", v, 32'h1234);
        peek(A(3, OFF_OVF), v);  check("ch3 no overflow", v, 32'h0);
        peek(A(3, OFF_TCON), v); check("ch3 no pend", v, 32'h3);
        wr_reg(A(3, OFF_TL), 32'hFFFF_FFFF);
        peek(A(3, OFF_TL), v);   check("ch3 tl write over tick", v, 32'hFFFF_FFFF);
        wr_reg(A(3, OFF_TCON), 32'h7);
        peek(A(3, OFF_TCON), v); check("ch3 hw set beats w1c", v, 32'h7);
        peek(A(3, OFF_TL), v);   check("ch3 reload th", v, 32'h5);
        peek(A(3, OFF_OVF), v);  check("ch3 ovf one", v, 32'h1);
        check("ch3 irq_vec", 32'(irq_vec), 32'h8);

        // Asynchronous reset with several channels counting and pending
        wr_reg(A(0, OFF_TCON), 32'h3);
        wr_reg(A(2, OFF_TCON), 32'h3);
        wr_reg(A(1, OFF_TCON), 32'h3);
        check("pre-reset irq_vec", 32'(irq_vec), 32'hD);
        check("pre-reset irqout", 32'(irqout), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset irqout", 32'(irqout), 32'h0);
        check("async reset irq_vec", 32'(irq_vec), 32'h0);
        for (int ch = 0; ch < 4; ch++) begin
            for (int o = 0; o < 16; o += 4) begin
                peek(A(ch, 4'(o)), v);
                check($sformatf("async reset ch%0d off%0h", ch, o), v, 32'h0);
            end
        end
        idle(1);
        reset = 1'b0;
        idle(2);
        peek(A(3, OFF_TL), v); check("post-reset idle tl", v, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
# timer_bank

Memory-mapped bank of `NUM_CH` independent reload timers on the CPU peripheral bus. It is the parametrised successor of the single TH/TL/TCON timer. Each channel adds a prescaler, a one-shot mode, a clear-on-read overflow counter and a per-channel interrupt line. The bank sits beside the existing peripheral decoder and drives the CPU interrupt request, masked while the CPU runs in kernel mode (PC31).

## Interface
- `NUM_CH`, 4: number of timer channels, 1..8.
- `CNT_W`, 32: counter/reload width, 8..32.
- `PRESC_W`, 8: prescaler field width, 1..8.
- `BASE_ADDR`, 32'h4000_0100: byte address of channel 0; channel i at `BASE_ADDR + 16*i`.
- `clk  in  1`: single clock; all state on rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `rd  in  1`: bus read strobe.
- `wr  in  1`: bus write strobe.
- `addr  in  32`: byte address.
- `wdata  in  32`: write data.
- `rdata  out  32`: read data, combinational.
- `PC31  in  1`: kernel-mode flag; 1 masks `irqout`.
- `irqout  out  1`: CPU interrupt request.
- `irq_vec  out  NUM_CH`: per-channel pending & IE, unmasked.

## Operation
- Register map per channel (offset from channel base):
  - +0x0 TH: reload value, R/W, low `CNT_W` bits.
  - +0x4 TL: count, R/W.
  - +0x8 TCON: R/W.
    - bit0 EN.
    - bit1 IE.
    - bit2 PEND.
    - bit3 ONESHOT.
    - bits[8+PRESC_W-1:8] PRESC.
  - +0xC OVF: read-only 8-bit overflow count, cleared on read.
- Unmapped addresses and `rd`=0 return 0. Writes to unmapped addresses and to OVF are ignored.
- Upper unused bits read 0.
- Prescaler: internal counter `pc` (PRESC_W bits) advances only while EN=1.
  - `pc`==PRESC: tick, `pc`<=0; otherwise `pc`<=`pc`+1.
  - PRESC=0 ticks every cycle.
- Tick with TL != all-ones: TL<=TL+1.
- Tick with TL == all-ones (overflow):
  - TL<=TH.
  - OVF<=OVF+1, saturating at 255.
  - PEND<=1 if IE=1.
  - EN<=0 if ONESHOT=1.
- TCON write:
  - Loads EN, IE, ONESHOT, PRESC.
  - PEND: writing 1 to bit2 clears it (W1C); writing 0 leaves it.
  - Resets `pc` to 0.
- `irq_vec[i]` = PEND_i & IE_i.
- `irqout` = ~PC31 & |irq_vec.

## Timing
- Reset values:
  - All TH, TL, TCON, OVF and `pc` = 0.
  - `irqout`=0, `irq_vec`=0, `rdata`=0.
- Reads are combinational in the same cycle as `rd`. Writes take effect at the next rising edge.
- OVF clear-on-read happens at the edge ending the `rd` cycle. The returned value is the pre-clear value.
- Simultaneous events, same edge, same channel:
  - TL write + tick: write wins; no increment, no overflow.
  - TH write + overflow: TL loads old TH.
  - TCON W1C of PEND + overflow setting PEND: PEND=1 (hardware set wins).
  - TCON write EN=1 + one-shot overflow clearing EN: write wins.
  - OVF read + overflow: returns old value; OVF becomes 1.
- From EN=1 with TL=all-ones and PRESC=0: PEND visible one cycle after the write edge. `irqout` follows combinationally.
- `reset` asserted mid-count: immediate return to reset values, no pending interrupt survives.

## Structure
- Package `timer_bank_pkg`:
  - Register offsets (TH/TL/TCON/OVF).
  - TCON bit positions (EN/IE/PEND/ONESHOT/PRESC_LSB).
  - OVF width (8).
- Sub-module `timer_channel`: one channel's TH/TL/TCON/OVF/`pc`.
  - Inputs: decoded per-register write/read strobes, `wdata`.
  - Outputs: register read values, `irq`.
- Top `timer_bank`:
  - Address decode: channel index = (`addr` - `BASE_ADDR`)>>4; offset = `addr[3:0]`.
  - `NUM_CH`-way generate of `timer_channel`.
  - Read mux and irq OR/mask.

## Test plan
- Reset, then read every register of all 4 channels -> all 0; `irqout`=0.
- Ch0: TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=0x3 -> PEND=1 and TL=0xFFFF_FFFC 2 cycles after write edge.
  - `irqout`=1 with PC31=0, 0 with PC31=1.
  - Write TCON=0x7 -> PEND clears, `irqout`=0.
- Ch1: PRESC=3, TL=0, EN -> after 8 cycles TL=2. TCON rewrite resets `pc` (next increment 4 cycles later).
- Ch2: ONESHOT=1, IE=0, TL=0xFFFF_FFFF, EN -> one overflow.
  - Then EN=0, TL=TH, PEND=0.
  - OVF reads 1 then 0.
  - 300 overflows (ONESHOT=0) -> OVF=255.
- Ch3: write TL on the overflow edge -> TL=written value, OVF unchanged. W1C PEND on overflow edge -> PEND stays 1.
- Assert `reset` while channels 0-3 count with PEND set -> all registers 0 immediately (asynchronous); `irqout`=0 before next clk edge.
